// File: rtl/alu_seq.sv
// alu_seq -- sequential signed integer ALU for the calculator controller.
//
// Add and subtract finish in one cycle. Multiply is a shift-add over W
// cycles and divide is a restoring divider over W cycles plus a sign-fix
// cycle, so the block needs no wide combinational multiplier or divider.
//
// Optional feature macro: ALU_DIV_EN
//   defined   : divider datapath plus the DIV and FIX states are built.
//   undefined : every divide command ends immediately with al_C=0, al_err=1.
//
// Ports:
//   Clock     in   system clock, rising edge
//   Reset     in   synchronous, active-low reset
//   al_A      in   W   operand A (dividend / minuend), signed
//   al_B      in   W   operand B (divisor / subtrahend), signed
//   al_cmd    in   AC_N operation select (AC_AD, AC_SB, AC_MU, AC_DI)
//   al_start  in   request, sampled only while idle
//   al_busy   out  high in every state except IDLE
//   al_done   out  one-cycle pulse, al_C / al_err valid from this cycle
//   al_C      out  W   result register, held until the next al_done
//   al_err    out  error flag of the last operation
//   al_state  out  3   current FSM state (debug observation)
//
// Handshake: a request is taken when al_start=1 at a rising edge while
// al_busy=0. al_busy then stays high through the al_done cycle; al_start
// is ignored during that whole window and nothing is queued. Operands are
// latched at the accepting edge, later input changes have no effect.

`ifndef CD_N
  `define CD_N 16
`endif
`ifndef AC_N
  `define AC_N 2
`endif
`ifndef AC_AD
  `define AC_AD 2'd0
`endif
`ifndef AC_SB
  `define AC_SB 2'd1
`endif
`ifndef AC_MU
  `define AC_MU 2'd2
`endif
`ifndef AC_DI
  `define AC_DI 2'd3
`endif

module alu_seq #(
  parameter int W = `CD_N
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [W-1:0]     al_A,
  input  logic [W-1:0]     al_B,
  input  logic [`AC_N-1:0] al_cmd,
  input  logic             al_start,
  output logic             al_busy,
  output logic             al_done,
  output logic [W-1:0]     al_C,
  output logic             al_err,
  output logic [2:0]       al_state
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q;
  logic [W-1:0]  c_q;
  logic          err_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] cnt_q;

  // Multiplier: multiplicand shifts left, multiplier shifts right, the
  // accumulator keeps only the low W bits, which is the signed product
  // mod 2^W regardless of operand signs.
  logic [W-1:0]  mcand_q;
  logic [W-1:0]  mplier_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  acc_d;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

`ifdef ALU_DIV_EN
  // Restoring divider on magnitudes. quo_q starts as |A| and its top bit
  // is shifted into the remainder each cycle while quotient bits enter at
  // the bottom. |B| <= 2^(W-1) keeps the shifted remainder within W bits.
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  dvs_q;
  logic          qneg_q;
  logic [W-1:0]  rem_sh;
  logic          rem_ge;
  logic [W-1:0]  rem_d;
  logic [W-1:0]  quo_d;
  logic [W-1:0]  abs_a;
  logic [W-1:0]  abs_b;

  always_comb begin
    rem_sh = {rem_q[W-2:0], quo_q[W-1]};
    rem_ge = (rem_sh >= dvs_q);
    rem_d  = rem_ge ? (rem_sh - dvs_q) : rem_sh;
    quo_d  = {quo_q[W-2:0], rem_ge};
    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
    abs_a  = al_A[W-1] ? (-al_A) : al_A;
    abs_b  = al_B[W-1] ? (-al_B) : al_B;
  end
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
`ifdef ALU_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (al_start) begin
            busy_q <= 1'b1;
            case (al_cmd)
              `AC_AD: begin
                c_q     <= al_A + al_B;
                err_q   <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
              `AC_SB: begin
                c_q     <= al_A - al_B;
                err_q   <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
              `AC_MU: begin
                mcand_q  <= al_A;
                mplier_q <= al_B;
                acc_q    <= '0;
                cnt_q    <= CNT_MAX;
                state_q  <= S_MUL;
              end
`ifdef ALU_DIV_EN
              `AC_DI: begin
                if (al_B == '0) begin
                  c_q     <= '0;
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  rem_q   <= '0;
                  quo_q   <= abs_a;
                  dvs_q   <= abs_b;
                  qneg_q  <= al_A[W-1] ^ al_B[W-1];
                  cnt_q   <= CNT_MAX;
                  state_q <= S_DIV;
                end
              end
`endif
              default: begin
                // Divide without the divider built, or an unknown command.
                c_q     <= '0;
                err_q   <= 1'b1;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            endcase
          end
        end

        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            c_q     <= acc_d;
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

`ifdef ALU_DIV_EN
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          // Negating the magnitude quotient gives truncation toward zero.
          c_q     <= qneg_q ? (-quo_q) : quo_q;
          err_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
`endif

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign al_busy  = busy_q;
  assign al_done  = done_q;
  assign al_C     = c_q;
  assign al_err   = err_q;
  assign al_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq at W=16.
// Expected results come from a behavioural model using signed integer
// arithmetic; expected latencies come from the command type.

`ifndef CD_N
  `define CD_N 16
`endif
`ifndef AC_N
  `define AC_N 2
`endif
`ifndef AC_AD
  `define AC_AD 2'd0
`endif
`ifndef AC_SB
  `define AC_SB 2'd1
`endif
`ifndef AC_MU
  `define AC_MU 2'd2
`endif
`ifndef AC_DI
  `define AC_DI 2'd3
`endif

module tb_alu_seq;

  localparam int W = 16;

  logic         Clock;
  logic         Reset;
  logic [W-1:0] al_A;
  logic [W-1:0] al_B;
  logic [1:0]   al_cmd;
  logic         al_start;
  logic         al_busy;
  logic         al_done;
  logic [W-1:0] al_C;
  logic         al_err;
  logic [2:0]   al_state;

  int n_vec;
  int n_err;

  alu_seq #(.W(W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .al_A     (al_A),
    .al_B     (al_B),
    .al_cmd   (al_cmd),
    .al_start (al_start),
    .al_busy  (al_busy),
    .al_done  (al_done),
    .al_C     (al_C),
    .al_err   (al_err),
    .al_state (al_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input logic [1:0] cmd, input logic [15:0] a,
                                input logic [15:0] b, output logic [15:0] c,
                                output logic err, output int lat);
    longint sa;
    longint sb;
    longint r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = 0;
    err = 1'b0;
    lat = 1;
    case (cmd)
      `AC_AD: r = sa + sb;
      `AC_SB: r = sa - sb;
      `AC_MU: begin
        r   = sa * sb;
        lat = W + 1;
      end
      default: begin
`ifdef ALU_DIV_EN
        if (sb == 0) begin
          err = 1'b1;
        end else begin
          r   = sa / sb;   // truncates toward zero
          lat = W + 2;
        end
`else
        err = 1'b1;
`endif
      end
    endcase
    c = r[15:0];
  endfunction

  function automatic logic [15:0] rnd_operand();
    logic [31:0] rv;
    logic [15:0] corner [6];
    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'hFFFF;
    corner[3] = 16'h7FFF; corner[4] = 16'h8000; corner[5] = 16'h8001;
    rv = $urandom;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return rv[15:0];
  endfunction

  // ---------------- driver ----------------
  // Starts one operation at the next edge and follows it to completion.
  // inj>0 pulses a second, different start request in that cycle.
  // Returns one cycle after al_done, the earliest cycle a new start is taken.
  task automatic run_op(input string tag, input logic [1:0] cmd,
                        input logic [15:0] a, input logic [15:0] b, input int inj);
    logic [15:0] exp_c;
    logic        exp_err;
    int          exp_lat;
    int          done_at;
    logic        busy_ok;
    logic [31:0] rv;
    model(cmd, a, b, exp_c, exp_err, exp_lat);
    al_cmd   = cmd;
    al_A     = a;
    al_B     = b;
    al_start = 1'b1;
    @(posedge Clock);   // cycle 0
    #1;
    al_start = 1'b0;
    rv = $urandom;
    al_A = rv[15:0];
    al_B = rv[31:16];
    al_cmd = 2'(rv[1:0]);
    done_at = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      @(negedge Clock);
      if (inj != 0 && n == inj) begin
        al_cmd   = `AC_AD;
        al_A     = 16'h1111;
        al_B     = 16'h2222;
        al_start = 1'b1;
      end else begin
        al_start = 1'b0;
      end
      if (!al_busy) busy_ok = 1'b0;
      if (al_done) done_at = n;
    end
    al_start = 1'b0;
    chk({tag, "/latency"}, 32'(done_at), 32'(exp_lat));
    chk({tag, "/C"}, 32'(al_C), 32'(exp_c));
    chk({tag, "/err"}, 32'(al_err), 32'(exp_err));
    chk({tag, "/busy_held"}, 32'(busy_ok), 32'd1);
    @(negedge Clock);
    chk({tag, "/done_pulse"}, 32'(al_done), 32'd0);
    chk({tag, "/busy_drop"}, 32'(al_busy), 32'd0);
  endtask

  // ---------------- scoreboard of directed vectors ----------------
  logic [1:0]  dir_cmd [$];
  logic [15:0] dir_a   [$];
  logic [15:0] dir_b   [$];

  task automatic add_dir(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] b);
    dir_cmd.push_back(cmd);
    dir_a.push_back(a);
    dir_b.push_back(b);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          dones;
    logic [31:0] rv;
    logic [1:0]  rcmd;
    n_vec    = 0;
    n_err    = 0;
    Reset    = 1'b0;
    al_A     = '0;
    al_B     = '0;
    al_cmd   = '0;
    al_start = 1'b0;

    // Reset held for two edges, then a start while still in reset.
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst/C", 32'(al_C), 32'd0);
    chk("rst/err", 32'(al_err), 32'd0);
    chk("rst/busy", 32'(al_busy), 32'd0);
    chk("rst/done", 32'(al_done), 32'd0);
    al_cmd = `AC_AD; al_A = 16'd1; al_B = 16'd1; al_start = 1'b1;
    @(negedge Clock);
    chk("rst_start/busy", 32'(al_busy), 32'd0);
    chk("rst_start/done", 32'(al_done), 32'd0);
    al_start = 1'b0;
    @(negedge Clock);
    chk("rst_start/C", 32'(al_C), 32'd0);
    Reset = 1'b1;
    @(negedge Clock);

    // Directed vectors, issued back to back.
    add_dir(`AC_AD, 16'd7, 16'd5);
    add_dir(`AC_SB, 16'd3, 16'd10);
    add_dir(`AC_AD, 16'h7FFF, 16'd1);
    add_dir(`AC_MU, 16'hFFFD, 16'd7);
    add_dir(`AC_MU, 16'd300, 16'd300);
    add_dir(`AC_DI, 16'hFFF9, 16'd2);
    add_dir(`AC_DI, 16'h8000, 16'hFFFF);
    add_dir(`AC_DI, 16'd5, 16'd0);
    add_dir(`AC_AD, 16'd1, 16'd2);
    add_dir(`AC_DI, 16'd10, 16'd2);
    add_dir(`AC_MU, 16'h8000, 16'hFFFF);
    add_dir(`AC_DI, 16'd7, 16'hFFFE);
    while (dir_cmd.size() > 0) begin
      run_op("dir", dir_cmd.pop_front(), dir_a.pop_front(), dir_b.pop_front(), 0);
    end

    // Ignored second start during a multiply, then a quiet window.
    run_op("mu_inject", `AC_MU, 16'd100, 16'd200, 5);
    dones = 0;
    repeat (25) begin
      @(negedge Clock);
      if (al_done) dones++;
    end
    chk("mu_inject/extra_done", 32'(dones), 32'd0);
    chk("mu_inject/C_hold", 32'(al_C), 32'h4E20);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      rv = $urandom;
      rcmd = 2'(rv[1:0]);
      run_op("rand", rcmd, rnd_operand(), rnd_operand(), 0);
    end

    // Reset in cycle 8 of a long operation.
    run_op("pre_rst", `AC_AD, 16'd9, 16'd9, 0);
`ifdef ALU_DIV_EN
    al_cmd = `AC_DI; al_A = 16'd1000; al_B = 16'd3;
`else
    al_cmd = `AC_MU; al_A = 16'd1000; al_B = 16'd3;
`endif
    al_start = 1'b1;
    @(posedge Clock);
    #1;
    al_start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge Clock);
      if (n == 8) Reset = 1'b0;
    end
    @(negedge Clock);
    chk("mid_rst/busy", 32'(al_busy), 32'd0);
    chk("mid_rst/C", 32'(al_C), 32'd0);
    chk("mid_rst/err", 32'(al_err), 32'd0);
    chk("mid_rst/done", 32'(al_done), 32'd0);
    Reset = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge Clock);
      if (al_done) dones++;
    end
    chk("mid_rst/no_done", 32'(dones), 32'd0);

    // Still operational after the mid-operation reset.
    run_op("post_rst", `AC_SB, 16'd0, 16'd1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential signed integer ALU that executes the operand/command triple produced by the calculator controller's ALU operand mux (`al_A`, `al_B`, `al_cmd`) and returns `al_C`. Add and subtract complete in one cycle. Multiply and divide are iterative, one bit per cycle, so no wide combinational multiplier or divider is needed. A start/busy/done handshake lets the controller FSM wait in its calc states until the result is valid.

## Interface
Parameters:
- `W`, default `` `CD_N ``: data width in bits; operands and result are two's-complement signed.

Ports:
- `Clock`  in  1  system clock; all state changes on rising edge.
- `Reset`  in  1  reset, synchronous, active-low.
- `al_A`  in  W  operand A (dividend / minuend).
- `al_B`  in  W  operand B (divisor / subtrahend).
- `al_cmd`  in  `` `AC_N ``  operation: `` `AC_AD ``, `` `AC_SB ``, `` `AC_MU ``, `` `AC_DI ``.
- `al_start`  in  1  request; sampled only in IDLE.
- `al_busy`  out  1  high in every state except IDLE.
- `al_done`  out  1  one-cycle pulse; `al_C` and `al_err` are valid from this cycle.
- `al_C`  out  W  result register; holds its value until the next `al_done`.
- `al_err`  out  1  error flag for the last operation (divide by zero, or divide compiled out).

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Reset (`Reset`=0 at an edge), from any state including mid-operation:
  - state IDLE;
  - `al_C`=0, `al_err`=0, `al_busy`=0, `al_done`=0;
  - iteration counter and internal accumulators cleared.
- IDLE, `al_start`=1: latch `al_A`, `al_B`, `al_cmd`, then dispatch on the command:
  - `` `AC_AD ``: `al_C`<=A+B mod 2^W, `al_err`<=0, go to DONE.
  - `` `AC_SB ``: `al_C`<=A−B mod 2^W, `al_err`<=0, go to DONE.
  - `` `AC_MU ``: load multiplicand and multiplier, go to MUL.
  - `` `AC_DI `` with B==0: `al_C`<=0, `al_err`<=1, go to DONE.
  - `` `AC_DI `` with B!=0: store |A| and |B|, record the quotient sign (sign A XOR sign B), clear the remainder, go to DIV.
- MUL: shift-add over W iterations (counter W−1 down to 0). The result is the low W bits of A×B, which equals the signed product mod 2^W. On the last iteration write `al_C`, set `al_err`<=0, go to DONE.
- DIV: restoring division of |A| by |B|, W iterations, then go to FIX.
- FIX: write `al_C` as the quotient, negated if the recorded sign is 1, so the result truncates toward zero. Set `al_err`<=0 and go to DONE. The remainder is discarded.
- DONE: `al_done`=1 for exactly this cycle, then go to IDLE.
- `al_start` is ignored in MUL, DIV, FIX and DONE; there is no queueing. Input changes after the start cycle have no effect.
- Overflow wraps silently, with no error:
  - −2^(W−1) / −1 gives −2^(W−1);
  - add, subtract and multiply results wrap mod 2^W.

## Timing
- Cycle 0 is the edge at which `al_start` is sampled in IDLE.
- Latency from start to `al_done` high:
  - AD, SB, and DI with divide by zero: cycle 1.
  - MU: cycle W+1.
  - DI: cycle W+2.
- `al_busy`=1 from cycle 1 through the `al_done` cycle inclusive. It drops in the cycle after `al_done`, which is the earliest cycle a new start is accepted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `ALU_DIV_EN` defined: the divider datapath and the DIV and FIX states are compiled in, with behaviour as above.
- `ALU_DIV_EN` undefined: the divider datapath is removed. Every `` `AC_DI `` goes IDLE→DONE with `al_C`=0 and `al_err`=1, latency 1. All other commands are unchanged.

## Test plan
All scenarios use W=16.
- Reset then idle: `Reset`=0 for 2 cycles -> `al_C`=0, `al_err`=0, `al_busy`=0, `al_done`=0. Assert `al_start` with `Reset`=0 -> no response.
- AD 7+5 -> `al_done` at cycle 1, `al_C`=12. Then SB 3−10 -> `al_C`=0xFFF9 (−7). Then AD 0x7FFF+1 -> 0x8000 with `al_err`=0.
- MU −3×7 -> `al_busy` for cycles 1..17, `al_done` at cycle 17, `al_C`=0xFFEB (−21). MU 300×300 -> 0x5F90 (90000 mod 65536).
- DI −7/2 -> `al_done` at cycle 18, `al_C`=0xFFFD (−3). DI 0x8000/0xFFFF -> 0x8000. DI 5/0 -> `al_done` at cycle 1, `al_C`=0, `al_err`=1. A following AD clears `al_err`.
- A second `al_start` pulsed in cycle 5 of a MU with different operands -> ignored: one `al_done`, first result only. A start in the cycle after `al_done` is accepted.
- `Reset`=0 in cycle 8 of a DI -> next cycle IDLE, `al_C`=0, `al_busy`=0. No `al_done` appears within 30 cycles.
- With `ALU_DIV_EN` undefined, DI 10/2 -> `al_done` at cycle 1, `al_C`=0, `al_err`=1.
